// File: rtl/spm_copy_dma_pkg.sv
// Shared SPM header: scratchpad geometry, bus width and the copy-engine
// state encoding used by spm_copy_dma.
//
// Contents:
//   SPM_ADDR_W  - SPM word-address width
//   WORD_W      - SPM data word width
//   SPM_DEPTH   - number of SPM words
//   SPM_BUS_W   - SPM bus width in bits
//   dma_state_t - copy engine states (IDLE, READ, WRITE, DONE)
package spm_copy_dma_pkg;

  localparam int SPM_ADDR_W = 12;
  localparam int WORD_W     = 32;
  localparam int SPM_DEPTH  = 1 << SPM_ADDR_W;
  localparam int SPM_BUS_W  = WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_t;

endpackage

// File: rtl/spm_copy_dma.sv
// spm_copy_dma: word-by-word copy engine for a single-port scratchpad.
// Each word takes one READ cycle (source address presented) and one WRITE
// cycle (registered read data written to the destination), so N words take
// 2N cycles plus a one-cycle DONE state.
//
// Ports:
//   clk, reset        - single clock, synchronous active-high reset
//   start             - command strobe, only accepted in IDLE
//   src_addr/dst_addr - first source/destination word address
//   len               - word count 0..2^SPM_ADDR_W
//   abort             - stop at the next word boundary
//   busy/done/aborted - status; aborted qualifies the done pulse
//   words_left        - remaining word count
//   spm_addr/spm_wr_data/spm_we/spm_rd_data - external RAM port
module spm_copy_dma #(
  parameter int SPM_ADDR_W = spm_copy_dma_pkg::SPM_ADDR_W,
  parameter int WORD_W     = spm_copy_dma_pkg::WORD_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SPM_ADDR_W-1:0] src_addr,
  input  logic [SPM_ADDR_W-1:0] dst_addr,
  input  logic [SPM_ADDR_W:0]   len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [SPM_ADDR_W:0]   words_left,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic [WORD_W-1:0]     spm_wr_data,
  output logic                  spm_we,
  input  logic [WORD_W-1:0]     spm_rd_data
);

  import spm_copy_dma_pkg::*;

  localparam int CNT_W = SPM_ADDR_W + 1;
  localparam logic [SPM_ADDR_W-1:0] ONE_ADDR = 1;
  localparam logic [CNT_W-1:0]      ONE_CNT  = 1;

  dma_state_t            state_q, state_d;
  logic [SPM_ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [SPM_ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [CNT_W-1:0]      left_q, left_d;
  logic [SPM_ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]     hold_q, hold_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  pend_q, pend_d;

  // Next-state and next-output logic. Every output is computed here for the
  // state being entered and then registered, so the outputs always describe
  // the current state. An abort seen during READ is remembered in pend so a
  // one-cycle abort pulse still ends the transfer after that word's WRITE.
  // Pointer arithmetic is left to wrap naturally at the address width.
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    left_d    = left_q;
    addr_d    = addr_q;
    hold_d    = hold_q;
    we_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    pend_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (len != '0) begin
            state_d   = ST_READ;
            src_ptr_d = src_addr;
            dst_ptr_d = dst_addr;
            left_d    = len;
            addr_d    = src_addr;
          end else begin
            state_d = ST_DONE;
            left_d  = '0;
            done_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        state_d = ST_WRITE;
        busy_d  = 1'b1;
        we_d    = 1'b1;
        addr_d  = dst_ptr_q;
        pend_d  = abort;
      end
      ST_WRITE: begin
        busy_d    = 1'b1;
        src_ptr_d = src_ptr_q + ONE_ADDR;
        dst_ptr_d = dst_ptr_q + ONE_ADDR;
        left_d    = left_q - ONE_CNT;
        hold_d    = spm_rd_data;
        if ((left_d == '0) || abort || pend_q) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          aborted_d = (left_d != '0);
        end else begin
          state_d = ST_READ;
          addr_d  = src_ptr_d;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset wins over everything and clears the
  // whole engine, which also abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      left_q    <= '0;
      addr_q    <= '0;
      hold_q    <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      left_q    <= left_d;
      addr_q    <= addr_d;
      hold_q    <= hold_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      pend_q    <= pend_d;
    end
  end

  // The RAM returns read data only during the WRITE cycle itself, so write
  // data is forwarded straight from the read port while writing and the
  // captured copy is shown at all other times.
  assign spm_wr_data = (state_q == ST_WRITE) ? spm_rd_data : hold_q;

  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign words_left = left_q;
  assign spm_addr   = addr_q;
  assign spm_we     = we_q;

endmodule

// File: tb/tb_spm_copy_dma.sv
// Testbench for spm_copy_dma. Provides a registered-read RAM, builds the
// expected cycle-by-cycle behaviour of each transfer from the copy rules,
// and compares the DUT against it every cycle, plus literal spot checks.
module tb_spm_copy_dma;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] src_addr;
  logic [11:0] dst_addr;
  logic [12:0] len;
  logic        abort;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [12:0] words_left;
  logic [11:0] spm_addr;
  logic [31:0] spm_wr_data;
  logic        spm_we;
  logic [31:0] spm_rd_data;

  typedef struct {
    logic        busy;
    logic        done;
    logic        aborted;
    logic        we;
    logic        chk_addr;
    logic [11:0] addr;
    logic        chk_wl;
    logic [12:0] wl;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] ram[4096];
  logic [31:0] model_mem[4096];
  bit          loaded = 1'b0;
  int          checks;
  int          errors;
  int          done_count;
  logic [12:0] done_wl;
  logic        done_ab;
  logic [11:0] last_addr;
  logic [31:0] last_data;

  spm_copy_dma dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .len(len),
    .abort(abort),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .words_left(words_left),
    .spm_addr(spm_addr),
    .spm_wr_data(spm_wr_data),
    .spm_we(spm_we),
    .spm_rd_data(spm_rd_data)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial RAM contents: every word tagged with its own address, except
  // the four A..D words of the basic copy test.
  function automatic logic [31:0] initVal(input int i);
    case (i)
      'h10:    return 32'hAAAA_AAAA;
      'h11:    return 32'hBBBB_BBBB;
      'h12:    return 32'hCCCC_CCCC;
      'h13:    return 32'hDDDD_DDDD;
      default: return 32'hC0DE_0000 | i;
    endcase
  endfunction

  // External single-port RAM with registered read data. It loads its
  // contents on the first clock edge, then serves the DUT.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) ram[i] <= initVal(i);
      loaded <= 1'b1;
    end else begin
      if (spm_we) ram[spm_addr] <= spm_wr_data;
      spm_rd_data <= ram[spm_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t rstEntry();
    exp_t e;
    e = '{default: '0};
    e.chk_addr = 1'b1;
    e.chk_wl   = 1'b1;
    e.chk_data = 1'b1;
    return e;
  endfunction

  function automatic exp_t idleEntry();
    exp_t e;
    e = '{default: '0};
    e.chk_addr = 1'b1;
    e.addr     = last_addr;
    e.chk_data = 1'b1;
    e.data     = last_data;
    return e;
  endfunction

  // Compare process: one expected record per cycle while a schedule is
  // queued, sampled mid-cycle on the falling edge. Done pulses are also
  // recorded so the tests can pin their final status literally.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      checkOutput("busy", {31'b0, busy}, {31'b0, cur.busy});
      checkOutput("done", {31'b0, done}, {31'b0, cur.done});
      checkOutput("aborted", {31'b0, aborted}, {31'b0, cur.aborted});
      checkOutput("spm_we", {31'b0, spm_we}, {31'b0, cur.we});
      if (cur.chk_addr) checkOutput("spm_addr", {20'b0, spm_addr}, {20'b0, cur.addr});
      if (cur.chk_wl) checkOutput("words_left", {19'b0, words_left}, {19'b0, cur.wl});
      if (cur.chk_data) checkOutput("spm_wr_data", spm_wr_data, cur.data);
    end
    if (done) begin
      done_count++;
      done_wl = words_left;
      done_ab = aborted;
    end
  end

  // Runs one command. The expected schedule is derived from the copy rules:
  // word k is a READ of src+k then a WRITE of dst+k carrying the current
  // memory value at src+k, then a single DONE cycle, then IDLE holding the
  // last address/data. abort_word cuts the copy after that word, restart_j
  // re-pulses start at that cycle, reset_j raises reset at that cycle.
  task automatic applyStimulus(input logic [11:0] s, input logic [11:0] d, input logic [12:0] n,
                               input int abort_word, input int restart_j, input int reset_j,
                               input bit abort_idle);
    exp_t sched[$];
    exp_t e;
    int   n_w;
    int   abort_j;
    int   g;
    bit   cut;
    n_w     = int'(n);
    abort_j = -1;
    if (abort_word >= 0) begin
      abort_j = 1 + 2 * abort_word;
      if (abort_word + 1 < n_w) n_w = abort_word + 1;
    end
    @(posedge clk);
    #1;
    sched.push_back(idleEntry());
    cut = 1'b0;
    for (int k = 0; k < n_w && !cut; k++) begin
      e = '{default: '0};
      e.busy     = 1'b1;
      e.chk_addr = 1'b1;
      e.addr     = 12'(s + k);
      e.chk_wl   = 1'b1;
      e.wl       = 13'(n - k);
      sched.push_back(e);
      if (sched.size() == reset_j + 1) begin
        cut = 1'b1;
      end else begin
        e.we       = 1'b1;
        e.addr     = 12'(d + k);
        e.chk_data = 1'b1;
        e.data     = model_mem[12'(s + k)];
        model_mem[12'(d + k)] = e.data;
        last_addr  = e.addr;
        last_data  = e.data;
        sched.push_back(e);
        if (sched.size() == reset_j + 1) cut = 1'b1;
      end
    end
    if (cut) begin
      repeat (3) sched.push_back(rstEntry());
      last_addr = '0;
      last_data = '0;
    end else begin
      e = '{default: '0};
      e.busy    = 1'b1;
      e.done    = 1'b1;
      e.aborted = (n_w < n);
      e.chk_wl  = 1'b1;
      e.wl      = 13'(n - n_w);
      sched.push_back(e);
      sched.push_back(idleEntry());
    end
    foreach (sched[i]) exp_q.push_back(sched[i]);
    src_addr = s;
    dst_addr = d;
    len      = n;
    start    = 1'b1;
    abort    = abort_idle;
    for (int j = 1; j < sched.size(); j++) begin
      @(posedge clk);
      #1;
      start = (j == restart_j);
      if (j == restart_j) begin
        src_addr = 12'h000;
        dst_addr = 12'h600;
        len      = 13'd5;
      end
      abort = (j == abort_j);
      reset = (j == reset_j);
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
    g = 0;
    while (exp_q.size() != 0 && g < 10) begin
      @(negedge clk);
      g++;
    end
    checkOutput("sched_drain", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int cnt_before;
    int bad;
    checks     = 0;
    errors     = 0;
    done_count = 0;
    done_wl    = '0;
    done_ab    = 1'b0;
    last_addr  = '0;
    last_data  = '0;
    start      = 1'b0;
    abort      = 1'b0;
    src_addr   = '0;
    dst_addr   = '0;
    len        = '0;
    for (int i = 0; i < 4096; i++) model_mem[i] = initVal(i);

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.push_back(rstEntry());

    $display("[TB] basic copy 0x010 -> 0x100, 4 words");
    applyStimulus(12'h010, 12'h100, 13'd4, -1, -1, -1, 1'b0);
    checkOutput("t1_ram100", ram[12'h100], 32'hAAAA_AAAA);
    checkOutput("t1_ram101", ram[12'h101], 32'hBBBB_BBBB);
    checkOutput("t1_ram102", ram[12'h102], 32'hCCCC_CCCC);
    checkOutput("t1_ram103", ram[12'h103], 32'hDDDD_DDDD);
    checkOutput("t1_aborted", {31'b0, done_ab}, 32'd0);

    $display("[TB] wrapping source 0xFFE -> 0x002, 4 words");
    applyStimulus(12'hFFE, 12'h002, 13'd4, -1, -1, -1, 1'b0);
    checkOutput("t2_ram002", ram[12'h002], 32'hC0DE_0FFE);
    checkOutput("t2_ram003", ram[12'h003], 32'hC0DE_0FFF);
    checkOutput("t2_ram004", ram[12'h004], 32'hC0DE_0000);
    checkOutput("t2_ram005", ram[12'h005], 32'hC0DE_0001);

    $display("[TB] zero-length command");
    cnt_before = done_count;
    applyStimulus(12'h020, 12'h030, 13'd0, -1, -1, -1, 1'b0);
    checkOutput("t3_ram030", ram[12'h030], 32'hC0DE_0030);
    checkOutput("t3_done_cnt", done_count, cnt_before + 1);

    $display("[TB] abort during third READ of 10");
    applyStimulus(12'h200, 12'h300, 13'd10, 2, -1, -1, 1'b0);
    checkOutput("t4_words_left", {19'b0, done_wl}, 32'd7);
    checkOutput("t4_aborted", {31'b0, done_ab}, 32'd1);
    checkOutput("t4_ram302", ram[12'h302], 32'hC0DE_0202);
    checkOutput("t4_ram303", ram[12'h303], 32'hC0DE_0303);

    $display("[TB] start re-pulsed while busy");
    applyStimulus(12'h400, 12'h500, 13'd3, -1, 3, -1, 1'b0);
    checkOutput("t5_ram502", ram[12'h502], 32'hC0DE_0402);
    checkOutput("t5_ram503", ram[12'h503], 32'hC0DE_0503);
    checkOutput("t5_ram600", ram[12'h600], 32'hC0DE_0600);

    $display("[TB] abort held in IDLE with start");
    applyStimulus(12'h040, 12'h050, 13'd2, -1, -1, -1, 1'b1);
    checkOutput("t6_ram051", ram[12'h051], 32'hC0DE_0041);
    checkOutput("t6_aborted", {31'b0, done_ab}, 32'd0);

    $display("[TB] overlapping ascending copy");
    applyStimulus(12'h700, 12'h701, 13'd3, -1, -1, -1, 1'b0);
    checkOutput("t7_ram703", ram[12'h703], 32'hC0DE_0700);

    $display("[TB] reset during WRITE of word 2 of 5");
    cnt_before = done_count;
    applyStimulus(12'h800, 12'h900, 13'd5, -1, -1, 4, 1'b0);
    checkOutput("t8_no_done", done_count, cnt_before);
    checkOutput("t8_ram901", ram[12'h901], 32'hC0DE_0801);
    checkOutput("t8_ram902", ram[12'h902], 32'hC0DE_0902);

    $display("[TB] single word after reset");
    applyStimulus(12'hA00, 12'hB00, 13'd1, -1, -1, -1, 1'b0);
    checkOutput("t9_ramB00", ram[12'hB00], 32'hC0DE_0A00);

    bad = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== model_mem[i]) bad++;
    checkOutput("ram_image_diffs", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
